// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Per-channel synchronizer and debouncer for the board push-buttons. Turns
//   bouncy, asynchronous key levels into clean levels for software polling and
//   produces one-cycle press/release pulses for local fabric logic.
//
//   Optional feature macro: KEY_AUTOREPEAT_EN
//     defined   -> press_pulse re-fires REPEAT_DELAY cycles after an accepted
//                  press, then every REPEAT_PERIOD cycles while held.
//     undefined -> no repeat logic; press_pulse fires once per accepted press.
//
// Parameters
//   N               number of key channels
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change (>= 1)
//   ACTIVE_LOW      1: raw level 0 = pressed; 0: raw level 1 = pressed
//   REPEAT_DELAY    hold cycles before the first auto-repeat pulse
//   REPEAT_PERIOD   cycles between subsequent auto-repeat pulses
//
// Ports
//   Clk            in   1  system clock
//   Reset          in   1  synchronous, active-high reset
//   keys_raw       in   N  asynchronous raw key levels from the pins
//   keys_clean     out  N  debounced level, same polarity as keys_raw
//   press_pulse    out  N  1-cycle high on accepted press (and auto-repeat)
//   release_pulse  out  N  1-cycle high on accepted release
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] keys_raw,
  output logic [N-1:0] keys_clean,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw/clean level that means "released".
  localparam logic             REL_LVL  = (ACTIVE_LOW != 0);

  // Elaboration-time sanity checks on the timing parameters.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // The debounce state is fully determined by whether the synchronized level
  // disagrees with the accepted level, so it is decoded rather than stored.
  typedef enum logic {
    ST_STABLE,
    ST_CHANGING
  } deb_state_e;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             clean_q;
    logic             press_q;
    logic             release_q;
    logic [CNT_W-1:0] cnt;
    deb_state_e       state;
    logic             accept;
    logic             s2_pressed;
    logic             rep_fire;

    // NOTE: every output of this block is assigned on every pass, so no latch
    // can be inferred.
    always_comb begin
      state      = (s2 != clean_q) ? ST_CHANGING : ST_STABLE;
      accept     = (state == ST_CHANGING) && (cnt == CNT_LAST);
      s2_pressed = (s2 != REL_LVL);
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values (the s1 -> s2 chain depends on it).
    always_ff @(posedge Clk) begin
      if (Reset) begin
        s1        <= REL_LVL;
        s2        <= REL_LVL;
        clean_q   <= REL_LVL;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1        <= keys_raw[g];
        s2        <= s1;
        // Pulses are registered alongside clean_q so they line up with the
        // keys_clean change.
        press_q   <= (accept && s2_pressed) || rep_fire;
        release_q <= accept && !s2_pressed;
        case (state)
          ST_STABLE: cnt <= '0;
          ST_CHANGING: begin
            if (accept) begin
              clean_q <= s2;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int R_W   = $clog2(R_MAX + 1);
    localparam logic [R_W-1:0] R_DELAY_LAST  = R_W'(REPEAT_DELAY - 1);
    localparam logic [R_W-1:0] R_PERIOD_LAST = R_W'(REPEAT_PERIOD - 1);

    logic [R_W-1:0] rcnt;
    logic           rphase;        // set once the first repeat has fired
    logic           clean_pressed;

    always_comb begin
      clean_pressed = (clean_q != REL_LVL);
      // No repeat in a cycle that accepts a change: that cycle either is the
      // press itself or ends the hold.
      rep_fire = clean_pressed && !accept &&
                 (rcnt == (rphase ? R_PERIOD_LAST : R_DELAY_LAST));
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (accept || !clean_pressed) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rep_fire) begin
        rcnt   <= '0;
        rphase <= 1'b1;
      end else begin
        rcnt <= rcnt + R_W'(1);
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign keys_clean[g]    = clean_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Self-checking bench for key_debounce (N=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3). A behavioural model tracks a two-sample
//   delay of keys_raw and accepts a new level once the last DEBOUNCE_CYCLES
//   synchronized samples all differ from the accepted level.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         Clk;
  logic         Reset;
  logic [N-1:0] keys_raw;
  logic [N-1:0] keys_clean;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;

  int vectors     = 0;
  int miscompares = 0;

  key_debounce #(
    .N               (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keys_raw      (keys_raw),
    .keys_clean    (keys_clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_s1, m_s2, m_clean, m_press, m_rel;
  bit           m_win [N][$];   // recent synchronized samples per channel
  int           m_since [N];    // cycles since the accepted press

  always @(posedge Clk) begin : model
    logic [N-1:0] s2_prev;
    bit           all_diff;
    if (Reset) begin
      m_s1    = '1;
      m_s2    = '1;
      m_clean = '1;
      m_press = '0;
      m_rel   = '0;
      for (int ch = 0; ch < N; ch++) begin
        m_win[ch].delete();
        m_since[ch] = 0;
      end
    end else begin
      s2_prev = m_s2;
      for (int ch = 0; ch < N; ch++) begin
        m_press[ch] = 1'b0;
        m_rel[ch]   = 1'b0;
        m_win[ch].push_back(s2_prev[ch]);
        if (m_win[ch].size() > D) void'(m_win[ch].pop_front());
        all_diff = (m_win[ch].size() == D);
        for (int k = 0; k < m_win[ch].size(); k++)
          if (m_win[ch][k] == m_clean[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_clean[ch] = s2_prev[ch];
          if (m_clean[ch] == 1'b0) begin
            m_press[ch] = 1'b1;
            m_since[ch] = 0;
          end else begin
            m_rel[ch] = 1'b1;
          end
          m_win[ch].delete();
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (m_clean[ch] == 1'b0) begin
          m_since[ch]++;
          if (m_since[ch] == RD || (m_since[ch] > RD && (m_since[ch] - RD) % RP == 0))
            m_press[ch] = 1'b1;
        end
`endif
      end
      m_s2 = m_s1;
      m_s1 = keys_raw;
    end
  end

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    Reset    = 1'b1;
    keys_raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
        miscompares++;
        $display("FAIL reset_state: got clean=%h press=%h rel=%h, want clean=f press=0 rel=0",
                 keys_clean, press_pulse, release_pulse);
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          (press_pulse | release_pulse) !== 4'h0) begin
        miscompares++;
        $display("FAIL idle_after_reset cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask

  task automatic test_press_release();
    keys_raw[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          press_pulse !== ((i == 6) ? 4'b0001 : 4'b0000) || keys_clean[0] !== (i < 6)) begin
        miscompares++;
        $display("FAIL press cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
    keys_raw[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          release_pulse !== ((i == 6) ? 4'b0001 : 4'b0000) || keys_clean[0] !== (i >= 6)) begin
        miscompares++;
        $display("FAIL release cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      keys_raw[1] = (i < 30) ? (((i / 2) % 2) == 1) : 1'b1;
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          keys_clean[1] !== 1'b1 || (press_pulse | release_pulse) !== 4'h0) begin
        miscompares++;
        $display("FAIL bounce cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask

  task automatic test_simultaneous();
    keys_raw[3:2] = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          press_pulse !== ((i == 6) ? 4'b1100 : 4'b0000)) begin
        miscompares++;
        $display("FAIL simul_press cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
    keys_raw[3:2] = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          release_pulse !== ((i == 6) ? 4'b1100 : 4'b0000) || press_pulse !== 4'h0) begin
        miscompares++;
        $display("FAIL simul_release cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    keys_raw[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel}) begin
        miscompares++;
        $display("FAIL pre_reset cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 i, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
    Reset = 1'b1;
    tick();
    vectors++;
    if ({keys_clean, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got clean=%h press=%h rel=%h, want clean=f press=0 rel=0",
               keys_clean, press_pulse, release_pulse);
    end
    Reset = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          press_pulse !== ((j == 6) ? 4'b0001 : 4'b0000)) begin
        miscompares++;
        $display("FAIL post_reset cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 j, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
    keys_raw[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel}) begin
        miscompares++;
        $display("FAIL post_reset_release cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 j, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      keys_raw = 4'($urandom());
      hold     = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        tick();
        vectors++;
        if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
            (press_pulse & release_pulse) !== 4'h0) begin
          miscompares++;
          $display("FAIL random seg%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                   seg, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
        end
      end
    end
    keys_raw = 4'hF;
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel}) begin
        miscompares++;
        $display("FAIL random_settle cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 c, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask

`ifdef KEY_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int  k;
    logic exp_p0;
    keys_raw[0] = 1'b0;
    for (int i = 1; i <= 6 + 24; i++) begin
      tick();
      k      = i - 6;
      exp_p0 = (k == 0) || (k == 10) || (k == 13) || (k == 16) || (k == 19) || (k == 22);
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          press_pulse[0] !== exp_p0) begin
        miscompares++;
        $display("FAIL autorepeat k=%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h p0=%b",
                 k, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel, exp_p0);
      end
    end
    keys_raw[0] = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      vectors++;
      if ({keys_clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel} ||
          (j >= 6 && press_pulse !== 4'h0)) begin
        miscompares++;
        $display("FAIL autorepeat_release cyc%0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                 j, keys_clean, press_pulse, release_pulse, m_clean, m_press, m_rel);
      end
    end
  endtask
`endif

  initial begin
    Reset    = 1'b1;
    keys_raw = 4'hF;
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
`ifdef KEY_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
